ofifo_drain: RTL

Read-side controller for the output FIFO bank. It pops complete rows (one psum per column) from the ofifo using that block's registered-read handshake, optionally applies ReLU per lane, and writes each row to the psum SRAM at consecutive addresses. It sits between the ofifo and the psum SRAM port and is started by the top-level core controller once per output tile.

---
 rtl/ofifo_drain.sv | 127 ++++++++++++
 1 files changed

// File: rtl/ofifo_drain.sv
// ofifo_drain: pops complete rows from the ofifo and writes them to consecutive psum SRAM addresses.
// Optional per-lane ReLU on the popped row is enabled by defining OFIFO_DRAIN_RELU_EN.
module ofifo_drain #(
   parameter int col     = 8,
   parameter int psum_bw = 16,
   parameter int addr_w  = 11
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [addr_w-1:0]        base_addr,
   input  logic [addr_w-1:0]        num_rows,
   input  logic [col*psum_bw-1:0]   ofifo_out,
   input  logic                     ofifo_valid,
   output logic                     ofifo_rd,
   output logic                     sram_cen,
   output logic                     sram_wen,
   output logic [addr_w-1:0]        sram_a,
   output logic [col*psum_bw-1:0]   sram_d,
   output logic                     busy,
   output logic                     done
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ISSUE   = 3'd1,
      CAPTURE = 3'd2,
      WRITE   = 3'd3,
      DONE    = 3'd4
   } state_t;

   localparam logic [addr_w-1:0] addr_zero = {addr_w{1'b0}};
   localparam logic [addr_w-1:0] addr_one  = {{(addr_w-1){1'b0}}, 1'b1};

   state_t             state;
   logic [addr_w-1:0]  addr_cnt;
   logic [addr_w-1:0]  rem_cnt;

   // Lane filter applied to the popped row before it is written to SRAM.
   function automatic logic [col*psum_bw-1:0] lane_filter(input logic [col*psum_bw-1:0] row);
      logic [col*psum_bw-1:0] res;
      res = row;
`ifdef OFIFO_DRAIN_RELU_EN
      for (int i = 0; i < col; i++) begin
         if (row[(i+1)*psum_bw-1]) begin
            res[i*psum_bw +: psum_bw] = {psum_bw{1'b0}};
         end
      end
`endif
      return res;
   endfunction

   // The read request is a decode of the state register gated by valid, so the ofifo
   // sees rd in the same cycle it reports a full row; it is confined to ISSUE, which
   // is never occupied for two cycles back-to-back with a granted pop.
   assign ofifo_rd = (state == ISSUE) && ofifo_valid;

   // Drain sequencer: state, counters and registered SRAM/status outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         addr_cnt <= addr_zero;
         rem_cnt  <= addr_zero;
         sram_cen <= 1'b1;
         sram_wen <= 1'b1;
         sram_a   <= addr_zero;
         sram_d   <= {(col*psum_bw){1'b0}};
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         sram_cen <= 1'b1;
         sram_wen <= 1'b1;
         done     <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  busy <= 1'b1;
                  if (num_rows == addr_zero) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     addr_cnt <= base_addr;
                     rem_cnt  <= num_rows;
                     state    <= ISSUE;
                  end
               end else begin
                  busy <= 1'b0;
               end
            end
            ISSUE: begin
               if (ofifo_valid) begin
                  state <= CAPTURE;
               end else begin
                  state <= ISSUE;
               end
            end
            CAPTURE: begin
               // Output registers are loaded here so the write appears during WRITE.
               sram_d   <= lane_filter(ofifo_out);
               sram_a   <= addr_cnt;
               sram_cen <= 1'b0;
               sram_wen <= 1'b0;
               state    <= WRITE;
            end
            WRITE: begin
               addr_cnt <= addr_cnt + addr_one;
               rem_cnt  <= rem_cnt - addr_one;
               if (rem_cnt == addr_one) begin
                  state <= DONE;
                  done  <= 1'b1;
               end else begin
                  state <= ISSUE;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
